// File: rtl/ns_resolve_pkg.sv
// Shared types for the namespace-aware symbol table sequencer.
// Names are stored zero-extended to NAME_MAX_W so entry_t stays a fixed-width packed struct.
package ns_resolve_pkg;

  localparam int NAME_MAX_W = 32;
  localparam logic [NAME_MAX_W-1:0] FLUSH_NAME = '1;

  typedef enum logic [1:0] {
    OP_LOOKUP     = 2'd0,
    OP_INS_LOCAL  = 2'd1,
    OP_INS_IMPORT = 2'd2,
    OP_INS_WILD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ORG_LOCAL    = 2'd0,
    ORG_IMPORT   = 2'd1,
    ORG_WILD     = 2'd2,
    ORG_PROMOTED = 2'd3
  } origin_e;

  typedef enum logic [2:0] {
    RC_OK       = 3'd0,
    RC_HIT      = 3'd1,
    RC_MISS     = 3'd2,
    RC_CONFLICT = 3'd3,
    RC_DUP      = 3'd4,
    RC_FULL     = 3'd5
  } code_e;

  typedef enum logic {
    NS_VALUE = 1'b0,
    NS_TYPE  = 1'b1
  } ns_e;

  typedef struct packed {
    logic                  vld;
    ns_e                   ns;
    logic [NAME_MAX_W-1:0] name;
    origin_e               origin;
  } entry_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the last granted requester gets lowest priority.
// Reset leaves the pointer favouring requester 0.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (en_i) begin
      if (last_q) begin
        gnt_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
      end else begin
        gnt_o = req_i[1] ? 2'b10 : {1'b0, req_i[0]};
      end
    end
    if (gnt_o[1]) begin
      last_d = 1'b1;
    end else if (gnt_o[0]) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ns_resolve_ctrl.sv
// Serialises insert/lookup/flush requests from two walkers onto one symbol table,
// scanning every entry per request and applying per-namespace import/conflict rules.
module ns_resolve_ctrl
  import ns_resolve_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NAME_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0][1:0]            req_op,
  input  logic [1:0]                 req_ns,
  input  logic [1:0][NAME_W-1:0]     req_name,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [2:0]                 rsp_code,
  output logic [$clog2(DEPTH)-1:0]   rsp_idx,
  output logic [1:0]                 rsp_origin
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [NAME_MAX_W-1:0] FLUSH_KEY = NAME_MAX_W'(FLUSH_NAME[NAME_W-1:0]);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_RESP} state_e;

  state_e                state_q, state_d;
  entry_t                tbl_q [DEPTH];
  logic                  arb_en, hs, gsel;
  logic [1:0]            gnt;

  logic                  lat_id_q;
  op_e                   lat_op_q;
  ns_e                   lat_ns_q;
  logic [NAME_MAX_W-1:0] lat_name_q;

  logic [IDX_W-1:0]      scan_idx_q;
  logic                  scan_last, scan_hit;
  logic                  match_q, free_q;
  logic [IDX_W-1:0]      match_idx_q, free_idx_q;

  logic                  c_flush, c_wr;
  logic [IDX_W-1:0]      c_wr_idx, c_idx;
  origin_e               c_wr_org, c_org, m_org;
  code_e                 c_code;

  logic                  rsp_id_q;
  code_e                 rsp_code_q;
  logic [IDX_W-1:0]      rsp_idx_q;
  origin_e               rsp_org_q;

  // Gated by rst so nothing is accepted while the block is held in reset.
  assign arb_en = (state_q == S_IDLE) && !rst;
  assign hs     = |gnt;
  assign gsel   = gnt[1];

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i (req_valid),
    .gnt_o (gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (hs) state_d = S_SCAN;
      S_SCAN:   if (scan_last) state_d = S_COMMIT;
      S_COMMIT: state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign scan_last = (scan_idx_q == IDX_W'(DEPTH - 1));
  assign scan_hit  = tbl_q[scan_idx_q].vld && (tbl_q[scan_idx_q].ns == lat_ns_q) &&
                     (tbl_q[scan_idx_q].name == lat_name_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_id_q    <= 1'b0;
      lat_op_q    <= OP_LOOKUP;
      lat_ns_q    <= NS_VALUE;
      lat_name_q  <= '0;
      scan_idx_q  <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      free_q      <= 1'b0;
      free_idx_q  <= '0;
    end else if (hs) begin
      lat_id_q    <= gsel;
      lat_op_q    <= op_e'(req_op[gsel]);
      lat_ns_q    <= ns_e'(req_ns[gsel]);
      lat_name_q  <= NAME_MAX_W'(req_name[gsel]);
      scan_idx_q  <= '0;
      match_q     <= 1'b0;
      free_q      <= 1'b0;
    end else if (state_q == S_SCAN) begin
      scan_idx_q <= scan_idx_q + IDX_W'(1);
      if (!match_q && scan_hit) begin
        match_q     <= 1'b1;
        match_idx_q <= scan_idx_q;
      end
      if (!free_q && !tbl_q[scan_idx_q].vld) begin
        free_q     <= 1'b1;
        free_idx_q <= scan_idx_q;
      end
    end
  end

  assign m_org = tbl_q[match_idx_q].origin;

  always_comb begin
    c_flush  = 1'b0;
    c_wr     = 1'b0;
    c_wr_idx = match_idx_q;
    c_wr_org = m_org;
    c_code   = RC_OK;
    c_idx    = '0;
    c_org    = ORG_LOCAL;
    if (lat_op_q == OP_INS_WILD && lat_name_q == FLUSH_KEY) begin
      c_flush = 1'b1;
    end else if (match_q) begin
      c_idx = match_idx_q;
      case (lat_op_q)
        OP_LOOKUP: begin
          c_code = RC_HIT;
          if (m_org == ORG_WILD) begin
            c_wr     = 1'b1;
            c_wr_org = ORG_PROMOTED;
          end
        end
        OP_INS_LOCAL: begin
          if (m_org == ORG_WILD) begin
            c_wr     = 1'b1;
            c_wr_org = ORG_LOCAL;
          end else if (m_org == ORG_LOCAL) begin
            c_code = RC_DUP;
          end else begin
            c_code = RC_CONFLICT;
          end
        end
        OP_INS_IMPORT: begin
          if (m_org == ORG_LOCAL) begin
            c_code = RC_CONFLICT;
          end else if (m_org == ORG_WILD) begin
            c_wr     = 1'b1;
            c_wr_org = ORG_PROMOTED;
          end
        end
        default: begin
          if (m_org == ORG_WILD) c_code = RC_DUP;
        end
      endcase
      c_org = c_wr_org;
    end else if (lat_op_q == OP_LOOKUP) begin
      c_code = RC_MISS;
    end else if (free_q) begin
      c_wr     = 1'b1;
      c_wr_idx = free_idx_q;
      c_idx    = free_idx_q;
      case (lat_op_q)
        OP_INS_LOCAL:  c_wr_org = ORG_LOCAL;
        OP_INS_IMPORT: c_wr_org = ORG_IMPORT;
        default:       c_wr_org = ORG_WILD;
      endcase
      c_org = c_wr_org;
    end else begin
      c_code = RC_FULL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (state_q == S_COMMIT) begin
      if (c_flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          tbl_q[i].vld <= 1'b0;
        end
      end else if (c_wr) begin
        tbl_q[c_wr_idx] <= '{vld: 1'b1, ns: lat_ns_q, name: lat_name_q, origin: c_wr_org};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_id_q   <= 1'b0;
      rsp_code_q <= RC_OK;
      rsp_idx_q  <= '0;
      rsp_org_q  <= ORG_LOCAL;
    end else if (state_q == S_COMMIT) begin
      rsp_id_q   <= lat_id_q;
      rsp_code_q <= c_code;
      rsp_idx_q  <= c_idx;
      rsp_org_q  <= c_org;
    end
  end

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_code   = rsp_code_q;
  assign rsp_idx    = rsp_idx_q;
  assign rsp_origin = rsp_org_q;

endmodule

// File: tb/tb_ns_resolve_ctrl.sv
// Directed and random checks of ns_resolve_ctrl against a table-level reference model.
module tb_ns_resolve_ctrl;

  localparam int DEPTH  = 8;
  localparam int NAME_W = 16;
  localparam int LKP = 0, INL = 1, INI = 2, INW = 3;
  localparam int C_OK = 0, C_HIT = 1, C_MISS = 2, C_CONF = 3, C_DUP = 4, C_FULL = 5;
  localparam int O_LOC = 0, O_IMP = 1, O_WLD = 2, O_PRO = 3;
  localparam int FLUSH = 16'hFFFF;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [1:0]               req_valid = '0;
  logic [1:0]               req_ready;
  logic [1:0][1:0]          req_op = '0;
  logic [1:0]               req_ns = '0;
  logic [1:0][NAME_W-1:0]   req_name = '0;
  logic                     rsp_valid;
  logic                     rsp_ready = 1'b0;
  logic                     rsp_id;
  logic [2:0]               rsp_code;
  logic [2:0]               rsp_idx;
  logic [1:0]               rsp_origin;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int exp_id, exp_code, exp_idx, exp_org;

  bit m_vld  [DEPTH];
  bit m_ns   [DEPTH];
  int m_name [DEPTH];
  int m_org  [DEPTH];

  ns_resolve_ctrl #(.DEPTH(DEPTH), .NAME_W(NAME_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_ns     (req_ns),
    .req_name   (req_name),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_code   (rsp_code),
    .rsp_idx    (rsp_idx),
    .rsp_origin (rsp_origin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
  endtask

  // Applies one request to the model table in service order and records the expected response.
  task automatic model_op(input int id, input int op, input int ns, input int name);
    int mi = -1;
    int fi = -1;
    exp_id = id; exp_code = C_OK; exp_idx = 0; exp_org = O_LOC;
    if (op == INW && name == FLUSH) begin
      model_reset();
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (mi < 0 && m_vld[i] && m_ns[i] == ns[0] && m_name[i] == name) mi = i;
      if (fi < 0 && !m_vld[i]) fi = i;
    end
    if (mi >= 0) begin
      exp_idx = mi;
      case (op)
        LKP: begin
          exp_code = C_HIT;
          if (m_org[mi] == O_WLD) m_org[mi] = O_PRO;
        end
        INL: begin
          if (m_org[mi] == O_WLD) m_org[mi] = O_LOC;
          else if (m_org[mi] == O_LOC) exp_code = C_DUP;
          else exp_code = C_CONF;
        end
        INI: begin
          if (m_org[mi] == O_LOC) exp_code = C_CONF;
          else if (m_org[mi] == O_WLD) m_org[mi] = O_PRO;
        end
        default: if (m_org[mi] == O_WLD) exp_code = C_DUP;
      endcase
      exp_org = m_org[mi];
    end else if (op == LKP) begin
      exp_code = C_MISS;
    end else if (fi >= 0) begin
      m_vld[fi] = 1'b1; m_ns[fi] = ns[0]; m_name[fi] = name;
      m_org[fi] = (op == INL) ? O_LOC : (op == INI) ? O_IMP : O_WLD;
      exp_idx = fi;
      exp_org = m_org[fi];
    end else begin
      exp_code = C_FULL;
    end
  endtask

  // Called just after a falling edge; returns at the falling edge after the handshake.
  task automatic issue(input int id, input int op, input int ns, input int name);
    int n = 0;
    req_op[id] = op[1:0]; req_ns[id] = ns[0]; req_name[id] = name[15:0]; req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("grant", req_ready[id], 1);
    hs_cyc = cyc;
    model_op(id, op, ns, name);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int hold);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk); n++;
    end
    check("rsp_seen", rsp_valid, 1);
    if (!rsp_valid) return;
    check("latency", cyc - hs_cyc, DEPTH + 2);
    check("rsp_id", rsp_id, exp_id);
    check("rsp_code", rsp_code, exp_code);
    check("rsp_idx", rsp_idx, exp_idx);
    check("rsp_origin", rsp_origin, exp_org);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_vld", rsp_valid, 1);
      check("hold_fields", {rsp_id, rsp_code, rsp_idx, rsp_origin},
            {exp_id[0], exp_code[2:0], exp_idx[2:0], exp_org[1:0]});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
  endtask

  task automatic txn(input int id, input int op, input int ns, input int name, input int hold);
    issue(id, op, ns, name);
    wait_rsp(hold);
  endtask

  initial begin
    int cnt;
    int op, nm;
    #1 rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    #1;
    check("rst_ready", req_ready, 0);
    req_valid = 2'b00;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_id, rsp_code, rsp_idx, rsp_origin}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Wildcard then local on the same name overwrites the candidate.
    txn(0, INW, 0, 16'h0010, 0);
    txn(0, INL, 0, 16'h0010, 0);

    // Namespace independence.
    txn(0, INW, 0, FLUSH, 0);
    txn(0, INW, 0, 16'h0010, 0);
    txn(0, INW, 1, 16'h0010, 0);
    txn(0, INI, 0, 16'h0010, 0);
    txn(0, INL, 0, 16'h0010, 0);
    txn(0, INL, 1, 16'h0010, 0);

    // Local blocks an explicit import; requester 1 leaves the pointer favouring 0.
    txn(0, INW, 0, FLUSH, 0);
    txn(0, INL, 0, 16'h0020, 0);
    txn(1, INI, 0, 16'h0020, 0);

    // Simultaneous requests.
    req_op[0] = 2'(LKP); req_ns[0] = 1'b0; req_name[0] = 16'h0020;
    req_op[1] = 2'(LKP); req_ns[1] = 1'b1; req_name[1] = 16'h0099;
    req_valid = 2'b11;
    #1;
    check("both_gnt0", req_ready, 2'b01);
    hs_cyc = cyc;
    model_op(0, LKP, 0, 16'h0020);
    @(negedge clk);
    req_valid[0] = 1'b0;
    check("busy_no_ready", req_ready, 0);
    wait_rsp(0);
    #1;
    check("both_gnt1", req_ready, 2'b10);
    hs_cyc = cyc;
    model_op(1, LKP, 1, 16'h0099);
    @(negedge clk);
    req_valid[1] = 1'b0;
    wait_rsp(0);

    // Fill, overflow, flush, lookup.
    txn(0, INW, 0, FLUSH, 0);
    for (int i = 0; i < DEPTH; i++) txn(0, INL, 0, 16'h0100 + i, 0);
    txn(0, INL, 0, 16'h0200, 0);
    txn(1, INW, 0, FLUSH, 0);
    txn(0, LKP, 0, 16'h0100, 0);

    // Backpressured response.
    txn(1, INL, 0, 16'h0055, 5);

    // Reset in the middle of a scan.
    issue(0, INL, 0, 16'h0077);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("rst_no_rsp", cnt, 0);
    txn(0, LKP, 0, 16'h0055, 0);

    // Random traffic over a small name set so matches and overflow are frequent.
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 3);
      nm = $urandom_range(1, 6);
      if ($urandom_range(0, 9) == 0) begin
        op = INW;
        nm = FLUSH;
      end
      txn($urandom_range(0, 1), op, $urandom_range(0, 1), nm, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
